// File: rtl/ts_rec_pkg.sv
// Shared constants and FSM state type for the transport-stream DDR recorder.
package ts_rec_pkg;
  localparam int         TS_PACKET_BYTES = 188;
  localparam logic [7:0] TS_SYNC_BYTE    = 8'h47;
  localparam logic [7:0] PAD_BYTE        = 8'hFF;
  localparam int         DDR_ADDR_W      = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } rec_state_e;
endpackage

// File: rtl/ts_word_fifo.sv
// 32-bit word FIFO; head is read straight from storage flops so it only moves on a pop.
module ts_word_fifo
  import ts_rec_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ts_ddr_packer.sv
// Transport-stream recorder: hunts for sync, packs bytes little-endian into words, writes them to DDR.
// Build macro TS_PACKER_STATS_EN enables the live PKT_COUNT / ERR_COUNT statistics.
module ts_ddr_packer
  import ts_rec_pkg::*;
#(
  parameter logic [DDR_ADDR_W-1:0] ADDR_LIMIT = 24'hFFFFFF,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  SYS_CLOCK,
  input  logic                  SYS_RESET,
  input  logic                  REC_EN,
  input  logic                  TS_VALID_IN,
  input  logic                  TS_SYNC_IN,
  input  logic [7:0]            TS_DATA_IN,
  output logic [DDR_ADDR_W-1:0] ddr_write_address,
  output logic                  ddr_write_write,
  output logic [31:0]           ddr_write_writedata,
  output logic [3:0]            ddr_write_byteenable,
  input  logic                  ddr_write_waitrequest,
  output logic                  BUSY,
  output logic                  OVERFLOW,
  output logic                  SYNC_ERR,
  output logic [DDR_ADDR_W-1:0] WR_PTR,
  output logic [15:0]           PKT_COUNT,
  output logic [7:0]            ERR_COUNT
);
  rec_state_e            state, state_nxt;
  logic [7:0]            byte_cnt;
  logic [1:0]            lane;
  logic [31:0]           wbuf, push_word;
  logic                  push_q, sync_err_q, overflow_q;
  logic                  sync_hit, hunt_take, cap, resync, lost, take, stop;
  logic                  fifo_full, fifo_empty, pop;
  logic [DDR_ADDR_W-1:0] addr;

  assign sync_hit  = TS_VALID_IN && TS_SYNC_IN && (TS_DATA_IN == TS_SYNC_BYTE);
  assign hunt_take = (state == HUNT) && REC_EN && sync_hit;
  assign cap       = (state == CAPTURE) && REC_EN && TS_VALID_IN;
  assign resync    = cap && TS_SYNC_IN && (byte_cnt != 8'd0);
  assign lost      = cap && !TS_SYNC_IN && (byte_cnt == 8'd0);
  assign take      = hunt_take || (cap && !lost);
  assign stop      = ((state == HUNT) || (state == CAPTURE)) && !REC_EN;
  assign lane      = (hunt_take || resync) ? 2'd0 : byte_cnt[1:0];

  always_ff @(posedge SYS_CLOCK or posedge SYS_RESET) begin
    if (SYS_RESET) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (REC_EN) state_nxt = HUNT;
      HUNT:    if (!REC_EN) state_nxt = FLUSH;
               else if (sync_hit) state_nxt = CAPTURE;
      CAPTURE: if (!REC_EN) state_nxt = FLUSH;
               else if (lost) state_nxt = HUNT;
      FLUSH:   if (fifo_empty && !push_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state != IDLE);
  end

  // wbuf is refilled with pad bytes at each word start, so a partial word is already padded
  always_ff @(posedge SYS_CLOCK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      byte_cnt   <= '0;
      wbuf       <= '1;
      push_q     <= 1'b0;
      push_word  <= '0;
      sync_err_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      sync_err_q <= resync || lost;
      if (((stop && state == CAPTURE) || resync) && byte_cnt[1:0] != 2'd0) begin
        push_q    <= 1'b1;
        push_word <= wbuf;
      end
      if (take) begin
        if (lane == 2'd3) begin
          push_q    <= 1'b1;
          push_word <= {TS_DATA_IN, wbuf[23:0]};
        end
        if (lane == 2'd0) wbuf <= {{3{PAD_BYTE}}, TS_DATA_IN};
        else              wbuf[{lane, 3'b000} +: 8] <= TS_DATA_IN;
        if (resync)                                        byte_cnt <= 8'd1;
        else if (byte_cnt == 8'(TS_PACKET_BYTES - 1))      byte_cnt <= '0;
        else                                               byte_cnt <= byte_cnt + 8'd1;
      end else if (stop || lost) begin
        byte_cnt <= '0;
      end
    end
  end

  ts_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (SYS_CLOCK),
    .rst       (SYS_RESET),
    .push      (push_q),
    .push_data (push_word),
    .pop       (pop),
    .head      (ddr_write_writedata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pop = !fifo_empty && !ddr_write_waitrequest;

  always_ff @(posedge SYS_CLOCK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      addr       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) addr <= (addr == ADDR_LIMIT) ? '0 : addr + 1'b1;
      if (push_q && fifo_full && !pop)            overflow_q <= 1'b1;
      else if (state == IDLE && state_nxt == HUNT) overflow_q <= 1'b0;
    end
  end

`ifdef TS_PACKER_STATS_EN
  logic [15:0] pkt_count;
  logic [7:0]  err_count;
  always_ff @(posedge SYS_CLOCK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (take && !resync && byte_cnt == 8'(TS_PACKET_BYTES - 1)) pkt_count <= pkt_count + 16'd1;
      if (resync && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
  assign PKT_COUNT = pkt_count;
  assign ERR_COUNT = err_count;
`else
  assign PKT_COUNT = '0;
  assign ERR_COUNT = '0;
`endif

  assign ddr_write_write      = !fifo_empty;
  assign ddr_write_address    = addr;
  assign ddr_write_byteenable = 4'hF;
  assign WR_PTR               = addr;
  assign SYNC_ERR             = sync_err_q;
  assign OVERFLOW             = overflow_q;
endmodule
